// File: rtl/attack_controller.sv
// attack_controller
// -----------------------------------------------------------------------------
// Per-player attack sequencer. On a frame tick (SCEN) with permission from
// player_state and a pressed attack button, it latches the attack and walks
// STARTUP -> ACTIVE -> RECOVERY. Each phase lasts a parameterised number of
// frame ticks, and then the sequencer returns to IDLE. A hitstun from
// game_resolver cancels the sequence at once.
//
// Handshake semantics: there is no valid/ready pair here. attack_busy is the
// "not ready" indication to player_state. While it is high, attack_enable and
// the buttons are ignored and nothing is queued. attack_done is a one-clk
// completion strobe and has no acknowledge.
//
// Ports:
//   clk            in   system clock
//   reset          in   asynchronous, active-high reset
//   SCEN           in   single-clk frame-tick enable
//   attack_enable  in   permission to start an attack (from player_state)
//   attack1        in   attack 1 button (level)
//   attack2        in   attack 2 button (level)
//   hitstun_active in   cancels any attack in progress
//   attack_busy    out  state != IDLE
//   hitbox_active  out  state == ACTIVE
//   attack_id      out  0=none, 1=attack1, 2=attack2
//   phase          out  current FSM state (IDLE=0 .. RECOVERY=3), doubles as debug view
//   attack_done    out  one-clk pulse on normal completion of recovery
// -----------------------------------------------------------------------------
module attack_controller #(
  parameter int STARTUP1 = 3,
  parameter int ACTIVE1  = 2,
  parameter int RECOVER1 = 4,
  parameter int STARTUP2 = 5,
  parameter int ACTIVE2  = 3,
  parameter int RECOVER2 = 8,
  parameter int CNT_W    = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       SCEN,
  input  logic       attack_enable,
  input  logic       attack1,
  input  logic       attack2,
  input  logic       hitstun_active,
  output logic       attack_busy,
  output logic       hitbox_active,
  output logic [1:0] attack_id,
  output logic [1:0] phase,
  output logic       attack_done
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_STARTUP  = 2'd1,
    S_ACTIVE   = 2'd2,
    S_RECOVERY = 2'd3
  } state_t;

  // Counter reload values. Each phase holds for N ticks, so the counter loads N-1.
  localparam logic [CNT_W-1:0] L_S1 = CNT_W'(STARTUP1 - 1);
  localparam logic [CNT_W-1:0] L_A1 = CNT_W'(ACTIVE1  - 1);
  localparam logic [CNT_W-1:0] L_R1 = CNT_W'(RECOVER1 - 1);
  localparam logic [CNT_W-1:0] L_S2 = CNT_W'(STARTUP2 - 1);
  localparam logic [CNT_W-1:0] L_A2 = CNT_W'(ACTIVE2  - 1);
  localparam logic [CNT_W-1:0] L_R2 = CNT_W'(RECOVER2 - 1);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_id;
  logic             r_busy;
  logic             r_hitbox;
  logic             r_done;

  state_t           w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [1:0]       w_id_nxt;
  logic             w_done_nxt;
  logic             w_is_a1;

  assign w_is_a1 = (r_id == 2'd1);

  // Next-state logic. Outside SCEN ticks everything holds. The one exception
  // is the done strobe, which defaults low so that it clears on the next edge.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_id_nxt    = r_id;
    w_done_nxt  = 1'b0;
    if (SCEN) begin
      case (r_state)
        S_IDLE: begin
          w_id_nxt = 2'd0;
          if (!hitstun_active && attack_enable && (attack1 || attack2)) begin
            w_state_nxt = S_STARTUP;
            // attack1 has priority when both buttons are pressed
            w_id_nxt    = attack1 ? 2'd1 : 2'd2;
            w_cnt_nxt   = attack1 ? L_S1 : L_S2;
          end
        end
        default: begin
          if (hitstun_active) begin
            w_state_nxt = S_IDLE;
            w_id_nxt    = 2'd0;
            w_cnt_nxt   = '0;
          end else if (r_cnt != '0) begin
            w_cnt_nxt = r_cnt - CNT_W'(1);
          end else begin
            case (r_state)
              S_STARTUP: begin
                w_state_nxt = S_ACTIVE;
                w_cnt_nxt   = w_is_a1 ? L_A1 : L_A2;
              end
              S_ACTIVE: begin
                w_state_nxt = S_RECOVERY;
                w_cnt_nxt   = w_is_a1 ? L_R1 : L_R2;
              end
              default: begin
                w_state_nxt = S_IDLE;
                w_id_nxt    = 2'd0;
                w_done_nxt  = 1'b1;
              end
            endcase
          end
        end
      endcase
    end
  end

  // busy and hitbox are registered from the next state, so they always
  // match r_state exactly and never glitch.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_id     <= 2'd0;
      r_busy   <= 1'b0;
      r_hitbox <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_id     <= w_id_nxt;
      r_busy   <= (w_state_nxt != S_IDLE);
      r_hitbox <= (w_state_nxt == S_ACTIVE);
      r_done   <= w_done_nxt;
    end
  end

  assign attack_busy   = r_busy;
  assign hitbox_active = r_hitbox;
  assign attack_id     = r_id;
  assign phase         = r_state;
  assign attack_done   = r_done;

endmodule

// File: tb/tb_attack_controller.sv
// Directed testbench for attack_controller with the default parameters
// (attack1 = 3/2/4 ticks, attack2 = 5/3/8 ticks).
module tb_attack_controller;

  logic       clk;
  logic       reset;
  logic       SCEN;
  logic       attack_enable;
  logic       attack1;
  logic       attack2;
  logic       hitstun_active;
  logic       attack_busy;
  logic       hitbox_active;
  logic [1:0] attack_id;
  logic [1:0] phase;
  logic       attack_done;

  int n_checks;
  int n_fail;

  attack_controller dut (
    .clk            (clk),
    .reset          (reset),
    .SCEN           (SCEN),
    .attack_enable  (attack_enable),
    .attack1        (attack1),
    .attack2        (attack2),
    .hitstun_active (hitstun_active),
    .attack_busy    (attack_busy),
    .hitbox_active  (hitbox_active),
    .attack_id      (attack_id),
    .phase          (phase),
    .attack_done    (attack_done)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_outs(input string tag, input logic [1:0] exp_phase,
                            input logic [1:0] exp_id, input logic exp_done);
    check({tag, ".phase"},  phase,         exp_phase);
    check({tag, ".busy"},   attack_busy,   exp_phase != 2'd0);
    check({tag, ".hitbox"}, hitbox_active, exp_phase == 2'd2);
    check({tag, ".id"},     attack_id,     exp_id);
    check({tag, ".done"},   attack_done,   exp_done);
  endtask

  // ---------------- driver tasks ----------------
  // One clk edge with SCEN=1. Outputs are then sampled 1ns after that edge.
  task automatic scen_tick();
    SCEN = 1'b1;
    @(posedge clk);
    #1;
    SCEN = 1'b0;
  endtask

  // One clk edge without SCEN.
  task automatic plain_clk();
    @(posedge clk);
    #1;
  endtask

  // n SCEN ticks. After each tick the outputs must show the given phase and id.
  task automatic expect_ticks(input string tag, input int n, input logic [1:0] p, input logic [1:0] id);
    for (int i = 0; i < n; i++) begin
      scen_tick();
      check_outs(tag, p, id, 1'b0);
    end
  endtask

  // The completing tick gives IDLE plus a done pulse. The pulse clears on the next plain clk.
  task automatic expect_done(input string tag);
    scen_tick();
    check_outs({tag, ".end"}, 2'd0, 2'd0, 1'b1);
    plain_clk();
    check_outs({tag, ".post"}, 2'd0, 2'd0, 1'b0);
  endtask

  task automatic release_inputs();
    attack_enable  = 1'b0;
    attack1        = 1'b0;
    attack2        = 1'b0;
    hitstun_active = 1'b0;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    n_fail++;
    $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
    $finish;
  end

  // ---------------- stimulus ----------------
  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b1;
    SCEN     = 1'b0;
    release_inputs();
    repeat (2) @(posedge clk);
    #1;
    check_outs("reset", 2'd0, 2'd0, 1'b0);
    reset = 1'b0;
    plain_clk();

    // Basic attack1: 3 startup, 2 active, 4 recovery, then done.
    attack_enable = 1'b1; attack1 = 1'b1;
    expect_ticks("a1.start", 1, 2'd1, 2'd1);
    release_inputs();
    expect_ticks("a1.startup", 2, 2'd1, 2'd1);
    expect_ticks("a1.active",  2, 2'd2, 2'd1);
    expect_ticks("a1.recov",   4, 2'd3, 2'd1);
    expect_done("a1");

    // Both buttons pressed: attack1 wins, busy for 9 ticks.
    attack_enable = 1'b1; attack1 = 1'b1; attack2 = 1'b1;
    expect_ticks("both.start", 1, 2'd1, 2'd1);
    release_inputs();
    expect_ticks("both.startup", 2, 2'd1, 2'd1);
    expect_ticks("both.active",  2, 2'd2, 2'd1);
    expect_ticks("both.recov",   4, 2'd3, 2'd1);
    expect_done("both");

    // Attack2 is cancelled by hitstun on the 2nd ACTIVE tick and then restarted.
    attack_enable = 1'b1; attack2 = 1'b1;
    expect_ticks("a2.start", 1, 2'd1, 2'd2);
    release_inputs();
    expect_ticks("a2.startup", 4, 2'd1, 2'd2);
    expect_ticks("a2.active",  1, 2'd2, 2'd2);
    hitstun_active = 1'b1;
    scen_tick();
    check_outs("a2.hitstun", 2'd0, 2'd0, 1'b0);
    plain_clk();
    check("a2.hitstun.nodone", attack_done, 1'b0);
    hitstun_active = 1'b0;
    attack_enable = 1'b1; attack2 = 1'b1;
    expect_ticks("a2r.start", 1, 2'd1, 2'd2);
    release_inputs();
    expect_ticks("a2r.startup", 4, 2'd1, 2'd2);
    expect_ticks("a2r.active",  3, 2'd2, 2'd2);
    expect_ticks("a2r.recov",   8, 2'd3, 2'd2);
    expect_done("a2r");

    // Attack2 is pressed during attack1 recovery and must be ignored.
    attack_enable = 1'b1; attack1 = 1'b1;
    expect_ticks("ign.start", 1, 2'd1, 2'd1);
    release_inputs();
    expect_ticks("ign.startup", 2, 2'd1, 2'd1);
    expect_ticks("ign.active",  2, 2'd2, 2'd1);
    expect_ticks("ign.recov",   1, 2'd3, 2'd1);
    attack_enable = 1'b1; attack2 = 1'b1;
    expect_ticks("ign.recov_press", 3, 2'd3, 2'd1);
    release_inputs();
    expect_done("ign");

    // Hitstun while IDLE blocks the start.
    attack_enable = 1'b1; attack1 = 1'b1; hitstun_active = 1'b1;
    expect_ticks("idle.hitstun", 2, 2'd0, 2'd0);
    release_inputs();

    // Asynchronous reset mid-STARTUP.
    attack_enable = 1'b1; attack1 = 1'b1;
    expect_ticks("rst.start", 1, 2'd1, 2'd1);
    release_inputs();
    expect_ticks("rst.startup", 1, 2'd1, 2'd1);
    #2;
    reset = 1'b1;
    #1;
    check_outs("rst.async", 2'd0, 2'd0, 1'b0);
    @(posedge clk);
    #3;
    reset = 1'b0;
    plain_clk();
    expect_ticks("rst.stay_idle", 3, 2'd0, 2'd0);

    // attack_enable=0 with attack1 held for 10 ticks: the FSM stays IDLE.
    attack1 = 1'b1;
    expect_ticks("noen", 10, 2'd0, 2'd0);

    // A pending start without SCEN does nothing.
    attack_enable = 1'b1;
    for (int i = 0; i < 3; i++) begin
      plain_clk();
      check_outs("noscen.pending", 2'd0, 2'd0, 1'b0);
    end

    // Held button restarts immediately after completion.
    expect_ticks("held.start",   1, 2'd1, 2'd1);
    expect_ticks("held.startup", 2, 2'd1, 2'd1);
    expect_ticks("held.active",  2, 2'd2, 2'd1);
    expect_ticks("held.recov",   4, 2'd3, 2'd1);
    expect_done("held");
    // The button is still held, so the first SCEN tick after IDLE starts a new attack.
    expect_ticks("held.restart", 1, 2'd1, 2'd1);
    release_inputs();
    expect_ticks("hold.startup", 2, 2'd1, 2'd1);
    expect_ticks("hold.active1", 1, 2'd2, 2'd1);
    // 20 clks without SCEN in the 1st ACTIVE tick. Phase and counter must hold.
    for (int i = 0; i < 20; i++) begin
      plain_clk();
      check_outs("hold.noscen", 2'd2, 2'd1, 1'b0);
    end
    // The counter held, so exactly one more ACTIVE tick remains.
    expect_ticks("hold.active2", 1, 2'd2, 2'd1);
    expect_ticks("hold.recov",   4, 2'd3, 2'd1);
    expect_done("hold");

    $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/attack_controller.md
Name: attack_controller

Overview:
Per-player attack sequencer sitting directly downstream of player_state. It consumes attack_enable and the raw attack buttons, runs the startup/active/recovery frame sequence for the selected attack, and drives attack_busy back into player_state. It also drives hitbox_active and attack_id to game_resolver. All timing is counted in SCEN (frame) ticks.

Parameters:
STARTUP1, 3, attack 1 startup length in SCEN ticks (>=1)
ACTIVE1, 2, attack 1 hitbox-active length in SCEN ticks (>=1)
RECOVER1, 4, attack 1 recovery length in SCEN ticks (>=1)
STARTUP2, 5, attack 2 startup length (>=1)
ACTIVE2, 3, attack 2 active length (>=1)
RECOVER2, 8, attack 2 recovery length (>=1)
CNT_W, 4, phase counter width; must hold max(all lengths)-1

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
SCEN  in  1  single-clk frame-tick enable; all state changes occur only on clk edges with SCEN=1
attack_enable  in  1  from player_state; permission to start an attack
attack1  in  1  attack 1 button (level)
attack2  in  1  attack 2 button (level)
hitstun_active  in  1  from game_resolver; cancels any attack in progress
attack_busy  out  1  to player_state; high whenever state != IDLE
hitbox_active  out  1  to game_resolver; high only in ACTIVE
attack_id  out  2  0=none, 1=attack1, 2=attack2; valid while attack_busy
phase  out  2  IDLE=0, STARTUP=1, ACTIVE=2, RECOVERY=3
attack_done  out  1  one-clk pulse on normal completion of recovery

Behaviour:
- Reset (asynchronous, any time, including mid-attack): state=IDLE, counter=0, attack_busy=0, hitbox_active=0, attack_id=0, phase=0, attack_done=0.
- All outputs are registered and hold between SCEN ticks. attack_done is the only output that changes on a non-SCEN cycle: it clears on the next clk edge after being set.
- FSM, evaluated only when SCEN=1. Priority is hitstun, then counter, then start.
- IDLE: if hitstun_active=0 and attack_enable=1 and (attack1 or attack2), latch attack_id, go to STARTUP, load counter=STARTUPx-1.
  - attack1 wins when both buttons are pressed.
  - Otherwise stay in IDLE with attack_id=0.
- STARTUP, ACTIVE, RECOVERY: if hitstun_active=1, go to IDLE immediately. Clear attack_id and hitbox_active. attack_done is not pulsed.
  - Else if counter != 0, decrement the counter.
  - Else advance: STARTUP->ACTIVE (load ACTIVEx-1), ACTIVE->RECOVERY (load RECOVERx-1), RECOVERY->IDLE (clear attack_id, set attack_done=1 for exactly one clk).
- Latency: a start condition sampled on SCEN tick N gives attack_busy=1 and phase=1 after that same clk edge. The phase occupies exactly the parameterised number of SCEN ticks. Total busy time is STARTUPx+ACTIVEx+RECOVERx ticks.
- While busy, attack_enable, attack1 and attack2 are ignored. There is no buffering or queuing of presses.
- Held button: if the button is still held and attack_enable=1 on the first SCEN tick after returning to IDLE, a new attack starts. No edge detection is done here; gating is player_state's job.
- Counter arithmetic: unsigned CNT_W bits, decremented only when nonzero, never wraps.
- attack_busy is a direct decode of state != IDLE. hitbox_active is a direct decode of state == ACTIVE. Both are registered alongside state, so they never glitch.
- SCEN=0 with a pending start: nothing happens until the next SCEN.

Test Plan:
- Reset, then attack_enable=1, attack1=1 for one SCEN tick -> phase goes 1 for 3 ticks, 2 for 2 ticks (hitbox_active=1), 3 for 4 ticks. attack_id=1 and attack_busy=1 for 9 ticks, then a single-clk attack_done=1 and all outputs back to 0.
- attack1=attack2=1 with attack_enable=1 -> attack_id=1; busy for 9 ticks, not 16.
- Attack2 started; hitstun_active=1 on the 2nd ACTIVE tick -> IDLE after that edge, hitbox_active=0, attack_id=0, no attack_done pulse. A new press with attack_enable=1 next tick restarts at STARTUP.
- Press attack2 during attack1 RECOVERY -> ignored. attack1 completes on schedule and attack_id stays 1 throughout.
- Assert reset asynchronously mid-STARTUP (between clk edges) -> all outputs go to 0 immediately. After reset is released, the FSM stays in IDLE without a new start condition.
- attack_enable=0 with attack1=1 for 10 ticks -> the FSM stays in IDLE; SCEN=0 for 20 clks mid-ACTIVE -> phase and counter hold unchanged.
